rr_mux_n: RTL and testbench

Registered N-channel, WIDTH-bit selector with a valid/ready handshake and round-robin arbitration. It is the parametrised successor of the CPU datapath's 2:1 16-bit select. It sits between multiple datapath sources (ALU result, memory read, immediate, I/O) and a single consumer such as the register-file write port or the bus. One output register stage decouples source and sink.

---
 rtl/rr_mux_n.sv | 177 +++++++++++++++++
 tb/tb_rr_mux_n.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_n.sv
// rr_mux_n: registered N-channel WIDTH-bit selector with valid/ready and round-robin arbitration.
// Define RR_MUX_BURST_LOCK_EN to add in_last and hold the mode=1 grant on one channel until end of burst.

module rr_mux_n_lane #(
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic             valid,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_ok,
  input  logic             lock_act,
  input  logic [SEL_W-1:0] lock_chan,
  input  logic             grant_any,
  input  logic [SEL_W-1:0] grant_idx,
  input  logic             ready_en,
  output logic             elig,
  output logic             ready
);
  localparam logic [SEL_W-1:0] ME = SEL_W'(IDX);

  logic pick;

  always_comb begin
    pick = 1'b0;
    if (mode) pick = ~lock_act | (lock_chan == ME);
    else      pick = sel_ok & (sel == ME);
  end

  assign elig  = valid & pick;
  assign ready = ready_en & grant_any & (grant_idx == ME);
endmodule

module rr_mux_n #(
  parameter  int WIDTH = 16,
  parameter  int N     = 4,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
`ifdef RR_MUX_BURST_LOCK_EN
  input  logic [N-1:0]         in_last,
`endif
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_chan
);
  logic [N-1:0][WIDTH-1:0] din;
  assign din = in_data;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;
  logic             lock_act;
  logic [SEL_W-1:0] lock_chan;
  logic             sel_ok, load_ok, grant_any, xfer, ready_en;
  logic [SEL_W-1:0] grant_idx;
  logic [N-1:0]     elig;

  assign load_ok  = ~out_valid_q | out_ready;
  // Reset also masks the grant so in_ready reads zero while rst is held.
  assign ready_en = load_ok & ~rst;
  assign xfer     = grant_any & load_ok;

  if ((1 << SEL_W) > N) begin : g_sel_chk
    assign sel_ok = ({1'b0, sel} < (SEL_W+1)'(N));
  end else begin : g_sel_all
    assign sel_ok = 1'b1;
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    rr_mux_n_lane #(.SEL_W(SEL_W), .IDX(k)) u_lane (
      .valid     (in_valid[k]),
      .mode      (mode),
      .sel       (sel),
      .sel_ok    (sel_ok),
      .lock_act  (lock_act),
      .lock_chan (lock_chan),
      .grant_any (grant_any),
      .grant_idx (grant_idx),
      .ready_en  (ready_en),
      .elig      (elig[k]),
      .ready     (in_ready[k])
    );
  end

  // Scan starts just after the last grant and wraps, so the previous winner goes last.
  always_comb begin
    logic [SEL_W:0] scan;
    grant_any = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int i = 1; i <= N; i++) begin
      scan = {1'b0, last_grant_q} + (SEL_W+1)'(i);
      if (scan >= (SEL_W+1)'(N)) scan = scan - (SEL_W+1)'(N);
      if (!grant_any && elig[scan[SEL_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      out_data_d  = din[grant_idx];
      out_chan_d  = grant_idx;
      out_valid_d = 1'b1;
      // Fixed-select traffic leaves the round-robin pointer alone.
      if (mode) last_grant_d = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      out_chan_q   <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= SEL_W'(N-1);
    end else begin
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef RR_MUX_BURST_LOCK_EN
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_chan_q, lock_chan_d;

  always_comb begin
    lock_d      = lock_q;
    lock_chan_d = lock_chan_q;
    if (!mode) begin
      lock_d = 1'b0;
    end else if (xfer) begin
      lock_d      = ~in_last[grant_idx];
      lock_chan_d = grant_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q      <= 1'b0;
      lock_chan_q <= '0;
    end else begin
      lock_q      <= lock_d;
      lock_chan_q <= lock_chan_d;
    end
  end

  assign lock_act  = lock_q;
  assign lock_chan = lock_chan_q;
`else
  assign lock_act  = 1'b0;
  assign lock_chan = '0;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
endmodule

// File: tb/tb_rr_mux_n.sv
// Bench for rr_mux_n: directed vector table, hand-written corner sequences, and random
// traffic checked against a channel-list arbitration model.
module tb_rr_mux_n;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
`ifdef RR_MUX_BURST_LOCK_EN
  logic [N-1:0]    in_last;
`endif
  logic            mode;
  logic [SW-1:0]   sel;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_chan;

  logic [W-1:0]    dat [N];
  int checks = 0;
  int passes = 0;

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign in_data[k*W +: W] = dat[k];
  end

  rr_mux_n #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef RR_MUX_BURST_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  always #5 clk = ~clk;

  // Reference model: output register contents plus the round-robin pointer and burst lock.
  bit         m_ov;
  logic [W-1:0] m_od;
  int         m_oc;
  int         m_ptr;
  bit         m_lock;
  int         m_lch;

  task automatic m_reset();
    m_ov = 0; m_od = '0; m_oc = 0; m_ptr = N - 1; m_lock = 0; m_lch = 0;
  endtask

  // Returns the granted channel, or -1 when nothing may transfer this cycle.
  function automatic int m_grant();
    int k;
    bit ok;
    if (m_ov && !out_ready) return -1;
    for (int i = 1; i <= N; i++) begin
      k = (m_ptr + i) % N;
      if (in_valid[SW'(k)]) begin
        if (mode) ok = !m_lock || (k == m_lch);
        else      ok = (int'(sel) == k);
        if (ok) return k;
      end
    end
    return -1;
  endfunction

  task automatic m_post(input int g);
    if (g >= 0) begin
      m_od = dat[SW'(g)];
      m_oc = g;
      m_ov = 1;
      if (mode) m_ptr = g;
`ifdef RR_MUX_BURST_LOCK_EN
      if (mode) begin
        m_lock = !in_last[SW'(g)];
        m_lch  = g;
      end
`endif
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (!mode) m_lock = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic m, input logic [SW-1:0] s, input logic [N-1:0] v, input logic ordy);
    mode = m; sel = s; in_valid = v; out_ready = ordy;
  endtask

  task automatic set_dat_default();
    for (int k = 0; k < N; k++) dat[k] = 16'(16'h00A0 + k);
  endtask

  // One cycle, entered and left at the falling edge: in_ready checked before the rising edge,
  // registered outputs checked just after it.
  task automatic run_cycle(input string tag);
    int g;
    logic [N-1:0] er;
    g  = m_grant();
    er = (g >= 0) ? (N'(1) << g) : '0;
    #1 check({tag, " in_ready"}, 32'(in_ready), 32'(er));
    @(posedge clk);
    m_post(g);
    #1;
    check({tag, " out_valid"}, 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      check({tag, " out_chan"}, 32'(out_chan), 32'(m_oc));
      check({tag, " out_data"}, 32'(out_data), 32'(m_od));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
`ifdef RR_MUX_BURST_LOCK_EN
    in_last = '1;
`endif
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic          m;
    logic [SW-1:0] s;
    logic [N-1:0]  v;
    logic          ordy;
    logic [N-1:0]  e_rdy;
    logic          e_ov;
    int            e_ch;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2};
    tbl[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 0};
    tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1};
    tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 3};
    tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 0};
    tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1};
    tbl[7]  = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1};
    tbl[8]  = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 1};
    tbl[9]  = '{1'b1, 2'd0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1};
    tbl[10] = '{1'b1, 2'd0, 4'b0010, 1'b0, 4'b0000, 1'b1, 1};
    tbl[11] = '{1'b1, 2'd0, 4'b0010, 1'b0, 4'b0000, 1'b1, 1};
    tbl[12] = '{1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 1};
    tbl[13] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 3};
    tbl[14] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 1};
    tbl[15] = '{1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1};

    set_dat_default();
    rst = 1'b1;
    drive(1'b1, '0, '1, 1'b1);
`ifdef RR_MUX_BURST_LOCK_EN
    in_last = '1;
`endif
    #3 check("in_ready held in reset", 32'(in_ready), 32'h0);
    do_reset();
    #1;
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_data", 32'(out_data), 32'h0);
    check("reset out_chan", 32'(out_chan), 32'h0);
    check("reset in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);

    // Directed vector table from the reset state.
    for (int i = 0; i < 16; i++) begin
      int g;
      drive(tbl[i].m, tbl[i].s, tbl[i].v, tbl[i].ordy);
      g = m_grant();
      #1 check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      @(posedge clk);
      m_post(g);
      #1;
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        check($sformatf("vec%0d out_chan", i), 32'(out_chan), 32'(tbl[i].e_ch));
        check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(16'h00A0) + 32'(tbl[i].e_ch));
      end
      @(negedge clk);
    end

    // Back-pressure: held beat stays stable while the source already shows new data.
    do_reset();
    dat[1] = 16'h1111;
    drive(1'b1, '0, 4'b0010, 1'b0);
    run_cycle("hold load");
    dat[1] = 16'h2222;
    for (int i = 0; i < 3; i++) run_cycle("hold stall");
    check("hold data", 32'(out_data), 32'h1111);
    drive(1'b1, '0, 4'b0010, 1'b1);
    run_cycle("hold pop+load");
    check("pop+load data", 32'(out_data), 32'h2222);

    // Asynchronous reset mid-beat.
    drive(1'b1, '0, '0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'h0);
    check("async rst in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    set_dat_default();
    drive(1'b1, '0, '1, 1'b1);
    run_cycle("post-rst");
    check("post-rst first grant", 32'(out_chan), 32'h0);

`ifdef RR_MUX_BURST_LOCK_EN
    // ch3 burst of three beats (with a gap) while ch0 stays valid.
    do_reset();
    set_dat_default();
    in_last = '1;
    drive(1'b1, '0, 4'b0100, 1'b1);
    run_cycle("lock pre");
    check("lock pre chan", 32'(out_chan), 32'h2);
    in_last = 4'b0111;
    drive(1'b1, '0, 4'b1001, 1'b1);
    run_cycle("lock b1");
    check("lock b1 chan", 32'(out_chan), 32'h3);
    run_cycle("lock b2");
    check("lock b2 chan", 32'(out_chan), 32'h3);
    drive(1'b1, '0, 4'b0001, 1'b1);
    run_cycle("lock gap");
    check("lock gap valid", 32'(out_valid), 32'h0);
    in_last = 4'b1111;
    drive(1'b1, '0, 4'b1001, 1'b1);
    run_cycle("lock b3");
    check("lock b3 chan", 32'(out_chan), 32'h3);
    run_cycle("lock release");
    check("lock release chan", 32'(out_chan), 32'h0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) dat[k] = 16'($urandom);
`ifdef RR_MUX_BURST_LOCK_EN
      in_last = 4'($urandom);
`endif
      drive($urandom_range(0, 3) != 0, SW'($urandom_range(0, N - 1)), 4'($urandom),
            $urandom_range(0, 3) != 0);
      run_cycle("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
